// File: rtl/flag_branch_controller_pkg.sv
// Shared constants for the NZCV flag sequencer: condition codes, status-register
// bit positions, NZCV nibble layout and controller state encodings.
package flag_branch_controller_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int SREG_N = 31;
    localparam int SREG_Z = 30;
    localparam int SREG_C = 29;
    localparam int SREG_V = 28;

    // Flags travel as a {N,Z,C,V} nibble everywhere inside the block.
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESOLVE = 2'd2
    } state_t;

endpackage

// File: rtl/flag_branch_controller_cond_eval.sv
// Combinational LEGv8 condition evaluator: (cond, NZCV) -> taken.
module flag_branch_controller_cond_eval
    import flag_branch_controller_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       taken
);

    logic n, z, c, v;

    always_comb begin
        n = nzcv[NZCV_N];
        z = nzcv[NZCV_Z];
        c = nzcv[NZCV_C];
        v = nzcv[NZCV_V];
        taken = 1'b1;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_HS: taken = c;
            COND_LO: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_HI: taken = c && !z;
            COND_LS: taken = !(c && !z);
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z && (n == v);
            COND_LE: taken = !(!z && (n == v));
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_branch_controller.sv
// NZCV commit pipe plus in-order B.cond resolver. Optional macro FLAG_BYPASS_EN
// resolves every branch the cycle after accept using forwarded flags.
module flag_branch_controller
    import flag_branch_controller_pkg::*;
#(
    parameter int COMMIT_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_valid,
    input  logic        negative_in,
    input  logic        zero_in,
    input  logic        carry_in,
    input  logic        overflow_in,
    input  logic        br_valid,
    input  logic [3:0]  br_cond,
    output logic        br_ready,
    output logic        br_done,
    output logic        br_taken,
    output logic        stall,
    output logic [2:0]  pending_cnt,
    output logic [31:0] sreg
);

    logic [COMMIT_LAT-1:0] pipe_valid;
    logic [3:0]            pipe_nzcv [COMMIT_LAT];
    logic [3:0]            arch_nzcv;
    logic [3:0]            in_nzcv;
    logic [3:0]            eval_nzcv;
    logic [3:0]            cond_q;
    logic [2:0]            wait_cnt;
    logic [2:0]            accept_cnt;
    logic                  commit;
    logic                  accept;
    logic                  cond_taken;
    state_t                state, state_next;

    assign in_nzcv = {negative_in, zero_in, carry_in, overflow_in};
    assign commit  = pipe_valid[COMMIT_LAT-1];
    assign accept  = br_valid && br_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= '0;
            arch_nzcv  <= '0;
            for (int i = 0; i < COMMIT_LAT; i++) pipe_nzcv[i] <= '0;
        end else begin
            pipe_valid[0] <= set_valid;
            pipe_nzcv[0]  <= in_nzcv;
            for (int i = 1; i < COMMIT_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_nzcv[i]  <= pipe_nzcv[i-1];
            end
            if (commit) arch_nzcv <= pipe_nzcv[COMMIT_LAT-1];
        end
    end

    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < COMMIT_LAT; i++) pending_cnt = pending_cnt + {2'b0, pipe_valid[i]};
    end

    always_comb begin
        sreg         = '0;
        sreg[SREG_N] = arch_nzcv[NZCV_N];
        sreg[SREG_Z] = arch_nzcv[NZCV_Z];
        sreg[SREG_C] = arch_nzcv[NZCV_C];
        sreg[SREG_V] = arch_nzcv[NZCV_V];
    end

    // Older updates still outstanding after this edge; a stage committing now is already done.
    assign accept_cnt = pending_cnt + {2'b0, set_valid} - {2'b0, commit};

`ifdef FLAG_BYPASS_EN
    logic [3:0] snap_nzcv, snap_q;

    always_comb begin
        snap_nzcv = arch_nzcv;
        for (int i = COMMIT_LAT - 1; i >= 0; i--) begin
            if (pipe_valid[i]) snap_nzcv = pipe_nzcv[i];
        end
        if (set_valid) snap_nzcv = in_nzcv;
    end

    always_ff @(posedge clk) begin
        if (reset)       snap_q <= '0;
        else if (accept) snap_q <= snap_nzcv;
    end

    assign eval_nzcv = snap_q;
`else
    assign eval_nzcv = arch_nzcv;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            cond_q   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                wait_cnt <= accept_cnt;
                cond_q   <= br_cond;
            end else if (state == ST_WAIT && commit) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
        end
    end

    flag_branch_controller_cond_eval u_cond_eval (
        .cond  (cond_q),
        .nzcv  (eval_nzcv),
        .taken (cond_taken)
    );

    // Outputs are forced quiet while reset is held so a dropped branch never pulses.
    always_comb begin
        state_next = state;
        br_ready   = 1'b0;
        br_done    = 1'b0;
        br_taken   = 1'b0;
        stall      = 1'b0;
        case (state)
            ST_IDLE: begin
                br_ready = !reset;
                if (accept) begin
`ifdef FLAG_BYPASS_EN
                    state_next = ST_RESOLVE;
`else
                    state_next = (accept_cnt == 3'd0) ? ST_RESOLVE : ST_WAIT;
`endif
                end
            end
            ST_WAIT: begin
                stall = !reset;
                if (commit && wait_cnt == 3'd1) state_next = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                br_done    = !reset;
                br_taken   = cond_taken && !reset;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_flag_branch_controller.sv
// Directed bench for flag_branch_controller (COMMIT_LAT=2); expectations follow
// the stalling build unless FLAG_BYPASS_EN is defined.
module tb_flag_branch_controller;

    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic        set_valid;
    logic        negative_in, zero_in, carry_in, overflow_in;
    logic        br_valid;
    logic [3:0]  br_cond;
    logic        br_ready, br_done, br_taken, stall;
    logic [2:0]  pending_cnt;
    logic [31:0] sreg;

    int checks   = 0;
    int failures = 0;

    flag_branch_controller #(.COMMIT_LAT(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .set_valid   (set_valid),
        .negative_in (negative_in),
        .zero_in     (zero_in),
        .carry_in    (carry_in),
        .overflow_in (overflow_in),
        .br_valid    (br_valid),
        .br_cond     (br_cond),
        .br_ready    (br_ready),
        .br_done     (br_done),
        .br_taken    (br_taken),
        .stall       (stall),
        .pending_cnt (pending_cnt),
        .sreg        (sreg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference table written per condition-pair: odd codes invert the even one, E/F always.
    function automatic logic model_taken(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b0;
        endcase
        return (cond[3:1] == 3'd7) ? 1'b1 : (base ^ cond[0]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_set(input logic [3:0] f);
        set_valid = 1'b1;
        {negative_in, zero_in, carry_in, overflow_in} = f;
    endtask

    task automatic drive_idle();
        set_valid = 1'b0;
        {negative_in, zero_in, carry_in, overflow_in} = 4'b0000;
        br_valid = 1'b0;
        br_cond  = 4'h0;
    endtask

    task automatic drive_branch(input logic [3:0] cond);
        br_valid = 1'b1;
        br_cond  = cond;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (br_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_held got=%b exp=0", br_ready); end
        reset = 1'b0;
        #1;
        checks++;
        if (sreg !== 32'h0) begin failures++; $display("FAIL reset_sreg got=%h exp=0", sreg); end
        checks++;
        if (pending_cnt !== 3'd0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", pending_cnt); end
        checks++;
        if (br_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", br_ready); end
        checks++;
        if ({br_done, br_taken, stall} !== 3'b000) begin
            failures++; $display("FAIL reset_outputs got=%b exp=000", {br_done, br_taken, stall});
        end
    endtask

    task automatic test_idle_branch();
        drive_branch(4'h0);
        step();
        br_valid = 1'b0;
        checks++;
        if (br_done !== 1'b1 || br_taken !== 1'b0) begin
            failures++; $display("FAIL idle_eq_not_taken got done=%b taken=%b exp done=1 taken=0", br_done, br_taken);
        end
        step();
        drive_set(4'b0100);
        step();
        set_valid = 1'b0;
        checks++;
        if (pending_cnt !== 3'd1) begin failures++; $display("FAIL set_pending got=%0d exp=1", pending_cnt); end
        step();
        step();
        checks++;
        if (sreg !== 32'h4000_0000 || pending_cnt !== 3'd0) begin
            failures++; $display("FAIL commit_z got sreg=%h pend=%0d exp sreg=40000000 pend=0", sreg, pending_cnt);
        end
        drive_branch(4'h0);
        step();
        br_valid = 1'b0;
        checks++;
        if (br_done !== 1'b1 || br_taken !== 1'b1) begin
            failures++; $display("FAIL idle_eq_taken got done=%b taken=%b exp done=1 taken=1", br_done, br_taken);
        end
        step();
    endtask

    task automatic test_same_cycle_set();
        int stalls, n;
        drive_set(4'b0000);
        step();
        set_valid = 1'b0;
        step(); step(); step();
        checks++;
        if (sreg !== 32'h0) begin failures++; $display("FAIL clear_flags got=%h exp=0", sreg); end
        drive_set(4'b0100);
        drive_branch(4'h0);
        step();
        drive_idle();
        stalls = 0;
        n = 1;
        while (!br_done && n < 20) begin
            if (stall) stalls++;
            step();
            n++;
        end
        checks++;
        if (!br_done) begin failures++; $display("FAIL same_cycle_timeout got done=0 exp=1"); end
`ifdef FLAG_BYPASS_EN
        checks++;
        if (stalls !== 0 || n !== 1) begin failures++; $display("FAIL same_cycle_latency got stalls=%0d cyc=%0d exp 0/1", stalls, n); end
`else
        checks++;
        if (stalls !== LAT || n !== LAT + 1) begin
            failures++; $display("FAIL same_cycle_latency got stalls=%0d cyc=%0d exp %0d/%0d", stalls, n, LAT, LAT + 1);
        end
`endif
        checks++;
        if (br_taken !== 1'b1) begin failures++; $display("FAIL same_cycle_taken got=%b exp=1", br_taken); end
        step(); step();
    endtask

    task automatic test_back_to_back();
        int n;
        drive_set(4'b0001); step();
        drive_set(4'b0000); step();
        drive_set(4'b1000); step();
        set_valid = 1'b0;
        drive_branch(4'hB);
        step();
        br_valid = 1'b0;
        drive_set(4'b0000);
        n = 1;
        while (!br_done && n < 20) begin
            step();
            n++;
        end
        checks++;
`ifdef FLAG_BYPASS_EN
        if (n !== 1) begin failures++; $display("FAIL b2b_latency got=%0d exp=1", n); end
`else
        if (n !== 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=2", n); end
`endif
        checks++;
        if (br_done !== 1'b1 || br_taken !== 1'b1) begin
            failures++; $display("FAIL b2b_lt_taken got done=%b taken=%b exp 1/1", br_done, br_taken);
        end
        step();
        set_valid = 1'b0;
        step(); step(); step();
        checks++;
        if (sreg !== 32'h0 || pending_cnt !== 3'd0) begin
            failures++; $display("FAIL b2b_drain got sreg=%h pend=%0d exp 0/0", sreg, pending_cnt);
        end
    endtask

    task automatic test_cond_sweep();
        logic [3:0] f, c;
        logic       exp_t;
        for (int fi = 0; fi < 16; fi++) begin
            f = 4'(fi);
            drive_set(f);
            step();
            set_valid = 1'b0;
            step(); step();
            for (int ci = 0; ci < 16; ci++) begin
                c = 4'(ci);
                exp_t = model_taken(c, f);
                drive_branch(c);
                step();
                br_valid = 1'b0;
                checks++;
                if (br_done !== 1'b1 || br_taken !== exp_t) begin
                    failures++;
                    $display("FAIL sweep cond=%h nzcv=%b got done=%b taken=%b exp done=1 taken=%b",
                             c, f, br_done, br_taken, exp_t);
                end
                step();
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int dones;
        drive_set(4'b1111);
        drive_branch(4'h0);
        step();
        drive_idle();
`ifndef FLAG_BYPASS_EN
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL wait_entered got stall=%b exp=1", stall); end
`endif
        reset = 1'b1;
        #1;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            if (br_done) dones++;
            step();
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (br_done) dones++;
            step();
        end
        checks++;
        if (dones !== 0) begin failures++; $display("FAIL reset_drop_done got=%0d exp=0", dones); end
        checks++;
        if (sreg !== 32'h0 || pending_cnt !== 3'd0 || br_ready !== 1'b1) begin
            failures++; $display("FAIL post_reset got sreg=%h pend=%0d ready=%b exp 0/0/1", sreg, pending_cnt, br_ready);
        end
    endtask

    task automatic test_no_starvation();
        int n, over;
        over = 0;
        for (int i = 0; i < 4; i++) begin
            drive_set(4'b0100);
            step();
            if (pending_cnt > 3'(LAT)) over++;
        end
        drive_set(4'b0000);
        drive_branch(4'hC);
        step();
        br_valid = 1'b0;
        drive_set(4'b0100);
        n = 1;
        while (!br_done && n < 30) begin
            if (pending_cnt > 3'(LAT)) over++;
            step();
            n++;
        end
        checks++;
`ifdef FLAG_BYPASS_EN
        if (n !== 1) begin failures++; $display("FAIL starve_latency got=%0d exp=1", n); end
`else
        if (n !== LAT + 1) begin failures++; $display("FAIL starve_latency got=%0d exp=%0d", n, LAT + 1); end
`endif
        checks++;
        if (br_done !== 1'b1 || br_taken !== 1'b1) begin
            failures++; $display("FAIL starve_gt_taken got done=%b taken=%b exp 1/1", br_done, br_taken);
        end
        checks++;
        if (over !== 0) begin failures++; $display("FAIL pending_bound got=%0d exp=0", over); end
        drive_idle();
        step(); step(); step();
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_idle_branch();
        test_same_cycle_set();
        test_back_to_back();
        test_cond_sweep();
        test_reset_in_wait();
        test_no_starvation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
